// File: rtl/arbitro_unidad_logica.sv
// ---------------------------------------------------------------------------
// arbitro_unidad_logica
//   Lets REQS requesters share one combinational unidad_logica. A round-robin
//   arbiter accepts one request at a time. The winner's operands and 3-bit
//   ALUControl code are registered into the unit. The registered result is
//   returned on a single valid/ready response channel, tagged with the ID of
//   the requester that owns it.
//
//   Ports
//     clk, rst      clock; asynchronous active-high reset
//     req_valid     per-requester request strobe
//     req_ready     one-hot (or zero) accept, combinational in IDLE
//     numero1_i     packed operand A, slice i belongs to requester i
//     numero2_i     packed operand B
//     control_i     packed 3-bit ALUControl codes
//     resp_valid    response channel valid
//     resp_ready    response channel ready
//     resp_id       requester that owns the response
//     resultado     registered logic-unit result
//     resp_err      unsupported control code (110/111); resultado is 0
//     busy          arbiter is not idle
//     op_count      accepted operations, saturating
//
// unidad_logica
//   Purely combinational N-bit logic unit.
//     000 AND   001 OR   010 XOR   011 NOR   100 NAND   101 XNOR
//     110/111 unsupported, output 0
// ---------------------------------------------------------------------------

module unidad_logica #(
    parameter int N = 8
) (
    input  logic [N-1:0] numero1,
    input  logic [N-1:0] numero2,
    input  logic [2:0]   alu_control,
    output logic [N-1:0] resultado
);
    always_comb begin
        resultado = '0;
        case (alu_control)
            3'b000:  resultado = numero1 & numero2;
            3'b001:  resultado = numero1 | numero2;
            3'b010:  resultado = numero1 ^ numero2;
            3'b011:  resultado = ~(numero1 | numero2);
            3'b100:  resultado = ~(numero1 & numero2);
            3'b101:  resultado = ~(numero1 ^ numero2);
            default: resultado = '0;
        endcase
    end
endmodule

module arbitro_unidad_logica #(
    parameter  int N    = 8,
    parameter  int REQS = 2,
    localparam int IDW  = (REQS > 1) ? $clog2(REQS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQS-1:0]   req_valid,
    output logic [REQS-1:0]   req_ready,
    input  logic [REQS*N-1:0] numero1_i,
    input  logic [REQS*N-1:0] numero2_i,
    input  logic [REQS*3-1:0] control_i,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [N-1:0]      resultado,
    output logic              resp_err,
    output logic              busy,
    output logic [15:0]       op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] id_reg;
    logic [N-1:0]   a_reg, b_reg;
    logic [2:0]     ctrl_reg;
    logic [N-1:0]   resultado_reg;
    logic [IDW-1:0] resp_id_reg;
    logic           resp_err_reg;
    logic [15:0]    op_count_reg;

    logic [IDW-1:0] grant;
    logic           grant_found;
    logic           accept;
    logic [N-1:0]   alu_out;
    logic [N-1:0]   a_sel, b_sel;
    logic [2:0]     ctrl_sel;

    // Round-robin search starting at ptr_reg, wrapping modulo REQS.
    always_comb begin
        int idx;
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < REQS; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= REQS) idx = idx - REQS;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = IDW'(idx);
            end
        end
    end

    assign accept = (state_reg == IDLE) && grant_found;

    assign a_sel    = numero1_i[int'(grant)*N +: N];
    assign b_sel    = numero2_i[int'(grant)*N +: N];
    assign ctrl_sel = control_i[int'(grant)*3 +: 3];

    // The accept strobe is suppressed while reset is held so that every
    // output reads zero for the whole reset interval.
    generate
        for (genvar gi = 0; gi < REQS; gi++) begin : g_ready
            assign req_ready[gi] = accept && !rst && (grant == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    unidad_logica #(.N(N)) u_logica (
        .numero1     (a_reg),
        .numero2     (b_reg),
        .alu_control (ctrl_reg),
        .resultado   (alu_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            ctrl_reg      <= '0;
            resultado_reg <= '0;
            resp_id_reg   <= '0;
            resp_err_reg  <= 1'b0;
            op_count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg    <= a_sel;
                b_reg    <= b_sel;
                ctrl_reg <= ctrl_sel;
                id_reg   <= grant;
                if (op_count_reg != 16'hFFFF) op_count_reg <= op_count_reg + 16'd1;
            end
            if (state_reg == EXEC) begin
                resp_err_reg  <= (ctrl_reg[2:1] == 2'b11);
                resultado_reg <= (ctrl_reg[2:1] == 2'b11) ? '0 : alu_out;
                resp_id_reg   <= id_reg;
            end
            // Next search starts just past the requester that was served.
            if (state_reg == RESP && resp_ready) begin
                ptr_reg <= (id_reg == IDW'(REQS - 1)) ? '0 : id_reg + IDW'(1);
            end
        end
    end

    assign resp_valid = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);
    assign resultado  = resultado_reg;
    assign resp_id    = resp_id_reg;
    assign resp_err   = resp_err_reg;
    assign op_count   = op_count_reg;
endmodule

// File: tb/tb_arbitro_unidad_logica.sv
module tb_arbitro_unidad_logica;
    localparam int N    = 8;
    localparam int REQS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [REQS-1:0]   req_valid;
    logic [REQS-1:0]   req_ready;
    logic [REQS*N-1:0] numero1_i;
    logic [REQS*N-1:0] numero2_i;
    logic [REQS*3-1:0] control_i;
    logic              resp_valid;
    logic              resp_ready;
    logic [0:0]        resp_id;
    logic [N-1:0]      resultado;
    logic              resp_err;
    logic              busy;
    logic [15:0]       op_count;

    arbitro_unidad_logica #(.N(N), .REQS(REQS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .numero1_i  (numero1_i),
        .numero2_i  (numero2_i),
        .control_i  (control_i),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resultado  (resultado),
        .resp_err   (resp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ptr_m = 0;
    logic [15:0] op_cnt_m = 16'd0;
    int op_num = 0;

    typedef struct {
        logic [1:0] v;
        logic [2:0] c0;
        logic [2:0] c1;
        logic       exp_id;
        logic [7:0] exp_res;
        logic       exp_err;
        int         hold;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result and error flag straight from the operation table.
    function automatic logic [8:0] model_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
        case (c)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, a ^ b};
            3'd3: return {1'b0, ~(a | b)};
            3'd4: return {1'b0, ~(a & b)};
            3'd5: return {1'b0, ~(a ^ b)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    function automatic int model_grant(input logic [1:0] v, input int p);
        for (int k = 0; k < REQS; k++) begin
            if (v[(p + k) % REQS]) return (p + k) % REQS;
        end
        return -1;
    endfunction

    task automatic run_op(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] c0, input logic [2:0] c1, input int hold,
                          input logic exp_id, input logic [7:0] exp_res, input logic exp_err);
        @(negedge clk);
        req_valid  = v;
        numero1_i  = {a, a};
        numero2_i  = {b, b};
        control_i  = {c1, c0};
        resp_ready = 1'b0;
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(2'b01 << exp_id));
        @(posedge clk);
        if (op_cnt_m != 16'hFFFF) op_cnt_m = op_cnt_m + 16'd1;
        @(negedge clk);
        req_valid = 2'b00;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_resp_valid", 32'(resp_valid), 32'd0);
        chk("exec_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resultado", 32'(resultado), 32'(exp_res));
        chk("resp_id", 32'(resp_id), 32'(exp_id));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("op_count", 32'(op_count), 32'(op_cnt_m));
        // Backpressure: other requests present, nothing must be accepted.
        req_valid = v;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_resultado", 32'(resultado), 32'(exp_res));
            chk("hold_resp_id", 32'(resp_id), 32'(exp_id));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_op_count", 32'(op_count), 32'(op_cnt_m));
        end
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        @(posedge clk);
        ptr_m = (int'(exp_id) + 1) % REQS;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        $display("op %0d: v=%b id=%0d a=%h b=%h ctrl=%b result=%h err=%b count=%0h",
                 op_num, v, exp_id, a, b, exp_id ? c1 : c0, resultado, resp_err, op_count);
        op_num++;
    endtask

    initial begin
        logic [1:0] v;
        logic [7:0] a, b;
        logic [2:0] c0, c1;
        logic [8:0] r;
        int g;

        tbl[0] = '{2'b01, 3'b000, 3'b000, 1'b0, 8'b10100001, 1'b0, 0};
        tbl[1] = '{2'b10, 3'b000, 3'b001, 1'b1, 8'b11101111, 1'b0, 0};
        tbl[2] = '{2'b11, 3'b000, 3'b001, 1'b0, 8'b10100001, 1'b0, 0};
        tbl[3] = '{2'b11, 3'b000, 3'b001, 1'b1, 8'b11101111, 1'b0, 0};
        tbl[4] = '{2'b11, 3'b000, 3'b001, 1'b0, 8'b10100001, 1'b0, 0};
        tbl[5] = '{2'b11, 3'b000, 3'b001, 1'b1, 8'b11101111, 1'b0, 0};
        tbl[6] = '{2'b11, 3'b010, 3'b001, 1'b0, 8'b01001110, 1'b0, 5};
        tbl[7] = '{2'b10, 3'b000, 3'b111, 1'b1, 8'b00000000, 1'b1, 0};
        tbl[8] = '{2'b01, 3'b010, 3'b000, 1'b0, 8'b01001110, 1'b0, 0};
        tbl[9] = '{2'b01, 3'b110, 3'b000, 1'b0, 8'b00000000, 1'b1, 2};

        rst        = 1'b1;
        req_valid  = 2'b00;
        numero1_i  = '0;
        numero2_i  = '0;
        control_i  = '0;
        resp_ready = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resultado", 32'(resultado), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        foreach (tbl[i]) begin
            run_op(tbl[i].v, 8'b11100101, 8'b10101011, tbl[i].c0, tbl[i].c1, tbl[i].hold,
                   tbl[i].exp_id, tbl[i].exp_res, tbl[i].exp_err);
        end

        // Reset during EXEC drops the operation and restarts arbitration at 0.
        run_op(2'b01, 8'hF0, 8'h3C, 3'b001, 3'b000, 0, 1'b0, 8'hFC, 1'b0);
        @(negedge clk);
        req_valid = 2'b11;
        control_i = 6'b000000;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_resultado", 32'(resultado), 32'd0);
        chk("mid_rst_resp_id", 32'(resp_id), 32'd0);
        chk("mid_rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        ptr_m    = 0;
        op_cnt_m = 16'd0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
        end
        run_op(2'b11, 8'hE5, 8'hAB, 3'b010, 3'b001, 0, 1'b0, 8'h4E, 1'b0);

        // Randomized operations against the reference model
        for (int t = 0; t < 40; t++) begin
            v  = 2'($urandom_range(1, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            c0 = 3'($urandom_range(0, 7));
            c1 = 3'($urandom_range(0, 7));
            g  = model_grant(v, ptr_m);
            r  = model_op(a, b, (g == 1) ? c1 : c0);
            run_op(v, a, b, c0, c1, $urandom_range(0, 3), g[0], r[7:0], r[8]);
        end

        // Saturation of the operation counter
        @(negedge clk);
        force dut.op_count_reg = 16'hFFFE;
        #1;
        release dut.op_count_reg;
        op_cnt_m = 16'hFFFE;
        chk("forced_op_count", 32'(op_count), 32'hFFFE);
        for (int t = 0; t < 3; t++) begin
            g = model_grant(2'b11, ptr_m);
            r = model_op(8'h5A, 8'h0F, (g == 1) ? 3'b011 : 3'b101);
            run_op(2'b11, 8'h5A, 8'h0F, 3'b101, 3'b011, 0, g[0], r[7:0], r[8]);
        end
        chk("sat_op_count", 32'(op_count), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
